// File: rtl/onehot_grant_encoder.sv
// onehot_grant_encoder
//   Converts a K x SIZE one-hot request matrix back into addresses. Rows that
//   select the same column are granted over successive beats, with the lowest
//   row index going first.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         request matrix handshake
//   onehot_in  [K*SIZE]         row k = bits [k*SIZE +: SIZE]
//   out_valid / out_ready       grant beat handshake
//   out_sel    [SIZE*BIT]       column j = granted row index
//   out_col_valid [SIZE]        column j granted this beat
//   out_row_grant [K]           rows granted this beat
//   out_addr   [K*AW]           encoded column per row, held for the transaction
//   out_row_valid [K]           row had a request
//   out_last                    final beat of the transaction
//   err_multi  [K]              row had more than one bit set

// Per-row capture: isolates the lowest set bit, encodes its index and flags
// rows that carry more than one bit.
module onehot_grant_row #(
   parameter int SIZE = 16,
   parameter int AW   = $clog2(SIZE)
) (
   input  logic [SIZE-1:0] row,
   output logic [SIZE-1:0] low,
   output logic [AW-1:0]   idx,
   output logic            multi,
   output logic            nz
);
   always_comb begin
      low = '0;
      idx = '0;
      // Walk downward so the lowest set bit is the one that sticks.
      for (int i = SIZE-1; i >= 0; i--) begin
         if (row[i]) begin
            low    = '0;
            low[i] = 1'b1;
            idx    = AW'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves something only if there were two or more.
   assign multi = |(row & (row - SIZE'(1)));
   assign nz    = |row;
endmodule

module onehot_grant_encoder #(
   parameter int K    = 4,
   parameter int SIZE = 16,
   parameter int BIT  = $clog2(K),
   parameter int AW   = $clog2(SIZE)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [K*SIZE-1:0]   onehot_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SIZE*BIT-1:0] out_sel,
   output logic [SIZE-1:0]     out_col_valid,
   output logic [K-1:0]        out_row_grant,
   output logic [K*AW-1:0]     out_addr,
   output logic [K-1:0]        out_row_valid,
   output logic                out_last,
   output logic [K-1:0]        err_multi
);
   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                 state_q, state_d;
   logic [K-1:0][SIZE-1:0] pend_q, pend_d;
   logic [K-1:0][AW-1:0]   addr_q, addr_d;
   logic [K-1:0]           row_valid_q, row_valid_d;
   logic [K-1:0]           err_multi_q, err_multi_d;

   logic [K-1:0][SIZE-1:0] cap_low;
   logic [K-1:0][AW-1:0]   cap_idx;
   logic [K-1:0]           cap_multi, cap_nz;

   for (genvar k = 0; k < K; k++) begin : g_row
      onehot_grant_row #(.SIZE(SIZE), .AW(AW)) u_row (
         .row   (onehot_in[k*SIZE +: SIZE]),
         .low   (cap_low[k]),
         .idx   (cap_idx[k]),
         .multi (cap_multi[k]),
         .nz    (cap_nz[k])
      );
   end

   // Column arbitration over the pending matrix: lowest pending row wins.
   logic [K-1:0][SIZE-1:0] win;
   logic [K-1:0][SIZE-1:0] remain;
   logic [SIZE*BIT-1:0]    sel_w;
   logic [SIZE-1:0]        col_any;
   logic [K-1:0]           row_win;
   logic                   last_w;

   always_comb begin
      win     = '0;
      sel_w   = '0;
      col_any = '0;
      for (int j = 0; j < SIZE; j++) begin
         for (int k = 0; k < K; k++) begin
            if (pend_q[k][j] && !col_any[j]) begin
               col_any[j]            = 1'b1;
               win[k][j]             = 1'b1;
               sel_w[j*BIT +: BIT]   = BIT'(k);
            end
         end
      end
      for (int k = 0; k < K; k++) row_win[k] = |win[k];
      remain = pend_q & ~win;
      last_w = ~|remain;
   end

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      addr_d      = addr_q;
      row_valid_d = row_valid_q;
      err_multi_d = err_multi_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               pend_d      = cap_low;
               addr_d      = cap_idx;
               row_valid_d = cap_nz;
               err_multi_d = cap_multi;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (out_ready) begin
               pend_d = remain;
               if (last_w) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         addr_q      <= '0;
         row_valid_q <= '0;
         err_multi_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         addr_q      <= addr_d;
         row_valid_q <= row_valid_d;
         err_multi_q <= err_multi_d;
      end
   end

   // Beat outputs only exist in ISSUE; in IDLE an empty pend would otherwise
   // report out_last=1.
   logic issue;
   assign issue         = (state_q == ISSUE);
   assign in_ready      = ~issue;
   assign out_valid     = issue;
   assign out_sel       = issue ? sel_w   : '0;
   assign out_col_valid = issue ? col_any : '0;
   assign out_row_grant = issue ? row_win : '0;
   assign out_last      = issue & last_w;
   assign out_addr      = addr_q;
   assign out_row_valid = row_valid_q;
   assign err_multi     = err_multi_q;
endmodule

// File: tb/tb_onehot_grant_encoder.sv
module tb_onehot_grant_encoder;
   localparam int K = 4, SIZE = 16, BIT = 2, AW = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid, in_ready, out_valid, out_ready, out_last;
   logic [K*SIZE-1:0]   onehot_in;
   logic [SIZE*BIT-1:0] out_sel;
   logic [SIZE-1:0]     out_col_valid;
   logic [K-1:0]        out_row_grant, out_row_valid, err_multi;
   logic [K*AW-1:0]     out_addr;

   int n_asrt = 0;
   int n_fail = 0;

   onehot_grant_encoder #(.K(K), .SIZE(SIZE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .onehot_in(onehot_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel), .out_col_valid(out_col_valid),
      .out_row_grant(out_row_grant), .out_addr(out_addr),
      .out_row_valid(out_row_valid), .out_last(out_last), .err_multi(err_multi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] oh(input int c);
      logic [SIZE-1:0] one;
      one = 1;
      return (c < 0) ? '0 : (one << c);
   endfunction

   function automatic logic [K*SIZE-1:0] mk(input int c3, input int c2, input int c1, input int c0);
      return {oh(c3), oh(c2), oh(c1), oh(c0)};
   endfunction

   // Reference: each row's request is its lowest set bit. A row is granted on
   // beat N where N = number of lower rows requesting the same column.
   task automatic do_txn(input logic [K*SIZE-1:0] m, input int stall, input int max_beats);
      int              col[K];
      int              rank[K];
      int              nb, st;
      logic [SIZE-1:0] r;
      logic [K*AW-1:0] ea;
      logic [K-1:0]    erv, eem, erg;
      logic [SIZE-1:0] ecv;
      logic [SIZE*BIT-1:0] esel;

      ea = '0; erv = '0; eem = '0;
      for (int k = 0; k < K; k++) begin
         r = m[k*SIZE +: SIZE];
         col[k] = -1;
         for (int i = SIZE-1; i >= 0; i--) if (r[i]) col[k] = i;
         erv[k] = (col[k] >= 0);
         eem[k] = ($countones(r) > 1);
         if (col[k] >= 0) ea[k*AW +: AW] = AW'(col[k]);
         rank[k] = 0;
         for (int kk = 0; kk < k; kk++)
            if (col[k] >= 0 && col[kk] == col[k]) rank[k]++;
      end
      nb = 1;
      for (int k = 0; k < K; k++) if (col[k] >= 0 && rank[k] + 1 > nb) nb = rank[k] + 1;

      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      chk("out_valid_idle", out_valid, 0);
      in_valid  = 1'b1;
      onehot_in = m;
      @(negedge clk);
      in_valid  = 1'b0;
      onehot_in = {$urandom, $urandom};
      chk("out_addr", out_addr, ea);
      chk("row_valid", out_row_valid, erv);
      chk("err_multi", err_multi, eem);

      for (int b = 0; b < nb && b < max_beats; b++) begin
         ecv = '0; esel = '0; erg = '0;
         for (int k = 0; k < K; k++) begin
            if (col[k] >= 0 && rank[k] == b) begin
               ecv[col[k]] = 1'b1;
               esel[col[k]*BIT +: BIT] = BIT'(k);
               erg[k] = 1'b1;
            end
         end
         st = (b == 0) ? stall : 0;
         for (int s = 0; s <= st; s++) begin
            chk("out_valid", out_valid, 1);
            chk("in_ready_busy", in_ready, 0);
            chk("col_valid", out_col_valid, ecv);
            chk("sel", out_sel, esel);
            chk("row_grant", out_row_grant, erg);
            chk("last", out_last, (b == nb-1));
            chk("addr_hold", out_addr, ea);
            out_ready = (s == st);
            // Upstream offering during stalls must be ignored.
            in_valid  = (s < st);
            @(negedge clk);
         end
         out_ready = 1'b0;
         in_valid  = 1'b0;
      end
      if (max_beats >= nb) begin
         chk("done_out_valid", out_valid, 0);
         chk("done_in_ready", in_ready, 1);
         chk("done_last", out_last, 0);
      end
   endtask

   initial begin
      logic [K*SIZE-1:0] m;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; onehot_in = '0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_col_valid", out_col_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // No conflict
      do_txn(mk(1, 0, 15, 14), 0, 99);
      chk("nc_addr_const", out_addr, 16'h10FE);
      // Full conflict
      do_txn(mk(5, 5, 5, 5), 0, 99);
      // Partial conflict with backpressure
      do_txn(mk(7, 7, 3, 3), 3, 99);
      // Empty matrix
      do_txn('0, 1, 99);
      chk("empty_rv", out_row_valid, 0);
      // Row 2 only
      do_txn(mk(-1, 9, -1, -1), 0, 99);
      chk("r2_rv_const", out_row_valid, 4'h4);
      chk("r2_addr_const", out_addr, 16'h0900);
      // Multi-bit row
      do_txn(64'h0030, 0, 99);
      chk("multi_err_const", err_multi, 4'h1);
      chk("multi_addr_const", out_addr, 16'h0004);

      // Reset after beat 2 of a full conflict
      do_txn(mk(5, 5, 5, 5), 0, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_col_valid", out_col_valid, 0);
      chk("mid_rst_addr", out_addr, 0);
      chk("mid_rst_rv", out_row_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(mk(2, 4, 6, 8), 0, 99);

      // Random matrices; half of them squeezed into 4 columns to force conflicts
      for (int t = 0; t < 30; t++) begin
         m = '0;
         for (int k = 0; k < K; k++) begin
            case ($urandom_range(0, 3))
               0:       m[k*SIZE +: SIZE] = '0;
               3:       m[k*SIZE +: SIZE] = SIZE'($urandom);
               default: m[k*SIZE +: SIZE] = oh($urandom_range(0, (t % 2) ? 3 : 15));
            endcase
         end
         do_txn(m, $urandom_range(0, 2), 99);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/onehot_grant_encoder.md
Name: onehot_grant_encoder

Overview:
- Inverse of the address decoder stage: accepts a K x SIZE one-hot request matrix, one row per generated address, and encodes it back to addresses.
- Bank conflicts (two rows selecting the same column) are resolved over successive beats, lowest row index first.
- Each beat emits a per-column requester index in the same packed layout the array-selector stage consumes, plus a column-valid mask.
- Sits between the decoder output and the bank array, serialising conflicting accesses.

Parameters:
K, 4, number of requester rows (generated addresses per transaction)
SIZE, 16, number of columns/banks; power of two
BIT, $clog2(K), derived: requester index width
AW, $clog2(SIZE), derived: column address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request matrix valid
in_ready  out  1  block can accept a matrix
onehot_in  in  K*SIZE  row k = bits [k*SIZE +: SIZE]
out_valid  out  1  grant beat valid
out_ready  in  1  downstream accepts beat
out_sel  out  SIZE*BIT  column j = bits [j*BIT +: BIT]; granted row index
out_col_valid  out  SIZE  column j granted this beat
out_row_grant  out  K  rows granted this beat
out_addr  out  K*AW  row k = bits [k*AW +: AW]; encoded column of row k; constant for the whole transaction
out_row_valid  out  K  row k had a request
out_last  out  1  final beat of the transaction
err_multi  out  K  row k had more than one bit set; held for the whole transaction

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; pend, addr, row_valid and err_multi registers cleared.
  - Outputs during reset: in_ready=1, out_valid=0, out_last=0, all other outputs 0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at an edge, capture per row into pend:
    - Keep only the lowest set bit of each row.
    - err_multi[k] = popcount(row k) > 1.
    - out_addr[k] = index of the lowest set bit; 0 if the row is empty.
    - out_row_valid[k] = row nonzero.
  - Go to ISSUE.
- State ISSUE:
  - in_ready=0, out_valid=1; all beat outputs are pure functions of the pend register.
  - For each column j: the granted row is the lowest k with pend[k][j]=1; out_col_valid[j] = any pend[.][j]; out_sel[j] = that k, or 0 if none.
  - out_row_grant = rows whose pend bit won its column.
  - out_last = 1 when no pend bits remain after removing this beat's grants.
  - On out_valid && out_ready: clear the granted bits from pend.
    - If out_last: go to IDLE.
    - Otherwise stay in ISSUE.
  - Without out_ready: hold every output stable; no bit is lost.
- Empty matrix (all zero): exactly one beat with out_col_valid=0, out_row_grant=0, out_last=1.
- Latency and throughput:
  - Matrix accepted at edge t → first beat visible after edge t (cycle t+1).
  - Beats per transaction = max column occupancy, range 1..K.
  - After the last-beat handshake, in_ready=1 the next cycle. There is no accept on the same edge as the last beat, so one idle cycle separates transactions.
- in_valid while in ISSUE is ignored; upstream holds it.
- out_addr, out_row_valid and err_multi stay stable from acceptance until the next acceptance.
- Reset asserted mid-transaction: pending grants are discarded and the block returns immediately to the reset state.

Test Plan:
- No conflict: rows at columns 14,15,0,1 → one beat; col_valid=0xC003; sel[14]=0, sel[15]=1, sel[0]=2, sel[1]=3; row_grant=0xF; out_last=1; out_addr={1,0,15,14} (row3..row0).
- Full conflict: all four rows at column 5, out_ready=1 → 4 beats with sel[5]=0,1,2,3 in order; row_grant=0x1,0x2,0x4,0x8; out_last only on beat 4; in_ready=1 the cycle after.
- Partial conflict plus backpressure:
  - Stimulus: rows at columns 3,3,7,7; out_ready low for 3 cycles, then high.
  - Required: out_valid held with beat1 outputs stable (col_valid=0x0088, sel[3]=0, sel[7]=2); then beat2 has sel[3]=1, sel[7]=3, out_last=1.
- Empty and partial rows:
  - All-zero matrix → single beat, col_valid=0, out_last=1.
  - Row 2 only at column 9 → row_valid=0x4, out_addr[2]=9.
- Multi-bit row: row0=0x0030 → err_multi=0x1; only column 4 granted; out_addr[0]=4.
- Reset mid-operation: full-conflict case with rst_n pulsed low after beat 2 → out_valid=0 and in_ready=1 immediately; the next matrix is processed normally.
